// File: rtl/dna_port_if.sv
// dna_port_if: device-DNA serial port bundle between a DNA consumer and the
// port responder.
//   master : consumer side; drives read/shift/din and the runtime override.
//   slave  : port side; returns dout plus the monitor outputs
//            (loaded, shift_count, word_done, captured, proto_err).
interface dna_port_if;
    logic        read;
    logic        shift;
    logic        din;
    logic        dout;
    logic        ovr_en;
    logic [56:0] ovr_value;
    logic        loaded;
    logic [6:0]  shift_count;
    logic        word_done;
    logic [56:0] captured;
    logic        proto_err;

    modport master (
        output read, shift, din, ovr_en, ovr_value,
        input  dout, loaded, shift_count, word_done, captured, proto_err
    );

    modport slave (
        input  read, shift, din, ovr_en, ovr_value,
        output dout, loaded, shift_count, word_done, captured, proto_err
    );
endinterface

// File: rtl/dna_port_model.sv
// dna_port_model: port-side model of the FPGA device-DNA primitive.
// A READ parallel-loads the 57-bit identifier (DNA_VALUE, or ovr_value when
// ovr_en is set); each SHIFT moves it MSB-first out of dout while din rolls in
// at bit 0. Emitted bits are collected in 'captured', and protocol misuse by
// the consumer latches proto_err until reset.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - dna_port_if.slave (read/shift/din/ovr in; dout and monitors out)
module dna_port_model #(
    parameter logic [56:0] DNA_VALUE = 57'h028340E18D8C85C,
    parameter int          DNA_BITS  = 57
) (
    input  logic       clk,
    input  logic       rst,
    dna_port_if.slave  bus
);
    localparam logic [6:0] CNT_MAX = 7'd127;
    localparam logic [6:0] CNT_END = 7'(DNA_BITS - 1);

    logic [DNA_BITS-1:0] sreg;
    logic [DNA_BITS-1:0] cap;
    logic [6:0]          cnt;
    logic                loaded;
    logic                word_done;
    logic                proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            cap       <= '0;
            cnt       <= '0;
            loaded    <= 1'b0;
            word_done <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (bus.read) begin
                // READ wins over a simultaneous SHIFT, which is itself an error.
                sreg   <= bus.ovr_en ? bus.ovr_value : DNA_VALUE;
                cap    <= '0;
                cnt    <= '0;
                loaded <= 1'b1;
                if (bus.shift)
                    proto_err <= 1'b1;
            end else if (bus.shift) begin
                sreg <= {sreg[DNA_BITS-2:0], bus.din};
                cap  <= {cap[DNA_BITS-2:0], sreg[DNA_BITS-1]};
                if (cnt != CNT_MAX)
                    cnt <= cnt + 7'd1;
                // The counter only passes 56->57 once per READ, so this pulses once.
                if (cnt == CNT_END)
                    word_done <= 1'b1;
                if (!loaded || cnt == CNT_MAX)
                    proto_err <= 1'b1;
            end
        end
    end

    assign bus.dout        = sreg[DNA_BITS-1];
    assign bus.loaded      = loaded;
    assign bus.shift_count = cnt;
    assign bus.word_done   = word_done;
    assign bus.captured    = cap;
    assign bus.proto_err   = proto_err;
endmodule
